// File: rtl/spi_master_sched_if.sv
// Requester handshake plus SPI pin bundle between spi_master_sched and its surroundings.
interface spi_master_sched_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [7:0]        rx_data;
   logic              busy;
   logic              sclk;
   logic [NREQ-1:0]   cs_n;
   logic              sending;
   logic              mosi;
   logic              miso;

   modport master (
      input  req, req_data, miso,
      output gnt, done, rx_data, busy, sclk, cs_n, sending, mosi
   );

   modport slave (
      output req, req_data, miso,
      input  gnt, done, rx_data, busy, sclk, cs_n, sending, mosi
   );
endinterface

// File: rtl/spi_master_sched.sv
// SPI mode-0 master sharing one bus round-robin among NREQ requesters, one byte per grant.
// done follows gnt by 17*CLK_DIV cycles; next gnt no earlier than CS_GAP+1 cycles after done.
module spi_master_sched #(
   parameter int NREQ    = 2,
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic               clk,
   input  logic               rst,
   spi_master_sched_if.master bus
);
   localparam int PW = $clog2(NREQ);
   localparam int IW = PW + 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [NREQ-1:0] sel_oh, sel_oh_nxt;
   logic [7:0]      tx_shift, tx_shift_nxt;
   logic [7:0]      rx_shift, rx_shift_nxt;
   logic [3:0]      bit_cnt, bit_cnt_nxt;
   logic [DW-1:0]   div_cnt, div_cnt_nxt;
   logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
   logic            sclk_r, sclk_nxt;
   logic            sending_r, sending_nxt;
   logic            mosi_r, mosi_nxt;
   logic            busy_r, busy_nxt;
   logic [NREQ-1:0] cs_n_r, cs_n_nxt;
   logic [NREQ-1:0] gnt_r, gnt_nxt;
   logic [NREQ-1:0] done_r, done_nxt;
   logic [7:0]      rx_data_r, rx_data_nxt;

   logic            found;
   logic [PW-1:0]   win;
   logic [IW-1:0]   cand;
   logic [NREQ-1:0] win_oh;
   logic [7:0]      win_dat;
   logic            div_wrap;

   assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      cand  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = {1'b0, ptr} + IW'(i);
         if (cand >= IW'(NREQ)) cand = cand - IW'(NREQ);
         if (!found && bus.req[cand[PW-1:0]]) begin
            found = 1'b1;
            win   = cand[PW-1:0];
         end
      end
      win_oh  = '0;
      win_dat = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (win == PW'(j)) begin
            win_oh[j] = 1'b1;
            win_dat   = bus.req_data[8*j +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= PW'(NREQ - 1);
         sel_oh    <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         gap_cnt   <= '0;
         sclk_r    <= 1'b0;
         sending_r <= 1'b0;
         mosi_r    <= 1'b0;
         busy_r    <= 1'b0;
         cs_n_r    <= '1;
         gnt_r     <= '0;
         done_r    <= '0;
         rx_data_r <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         sel_oh    <= sel_oh_nxt;
         tx_shift  <= tx_shift_nxt;
         rx_shift  <= rx_shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         div_cnt   <= div_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         sclk_r    <= sclk_nxt;
         sending_r <= sending_nxt;
         mosi_r    <= mosi_nxt;
         busy_r    <= busy_nxt;
         cs_n_r    <= cs_n_nxt;
         gnt_r     <= gnt_nxt;
         done_r    <= done_nxt;
         rx_data_r <= rx_data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = SETUP;
         SETUP:   if (div_wrap) state_nxt = SHIFT;
         // Leaving on the 8th fall: sclk is high and all 8 bits have been sampled.
         SHIFT:   if (div_wrap && sclk_r && bit_cnt == 4'd8) state_nxt = HOLD;
         HOLD:    if (div_wrap) state_nxt = (CS_GAP == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == GW'(CS_GAP - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ptr_nxt      = ptr;
      sel_oh_nxt   = sel_oh;
      tx_shift_nxt = tx_shift;
      rx_shift_nxt = rx_shift;
      bit_cnt_nxt  = bit_cnt;
      div_cnt_nxt  = div_cnt;
      gap_cnt_nxt  = gap_cnt;
      sclk_nxt     = sclk_r;
      sending_nxt  = sending_r;
      mosi_nxt     = mosi_r;
      cs_n_nxt     = cs_n_r;
      rx_data_nxt  = rx_data_r;
      gnt_nxt      = '0;
      done_nxt     = '0;
      busy_nxt     = (state_nxt != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               ptr_nxt      = win;
               sel_oh_nxt   = win_oh;
               gnt_nxt      = win_oh;
               tx_shift_nxt = win_dat;
               cs_n_nxt     = ~win_oh;
               sending_nxt  = 1'b1;
               mosi_nxt     = win_dat[7];
               bit_cnt_nxt  = '0;
               div_cnt_nxt  = '0;
            end
         end
         SETUP: begin
            div_cnt_nxt = div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
               sclk_nxt     = 1'b1;
               rx_shift_nxt = {rx_shift[6:0], bus.miso};
               bit_cnt_nxt  = bit_cnt + 4'd1;
            end
         end
         SHIFT: begin
            div_cnt_nxt = div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
               sclk_nxt = ~sclk_r;
               if (!sclk_r) begin
                  rx_shift_nxt = {rx_shift[6:0], bus.miso};
                  bit_cnt_nxt  = bit_cnt + 4'd1;
               end else if (bit_cnt < 4'd8) begin
                  tx_shift_nxt = {tx_shift[6:0], 1'b0};
                  mosi_nxt     = tx_shift[6];
               end
            end
         end
         HOLD: begin
            div_cnt_nxt = div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
               cs_n_nxt    = '1;
               sending_nxt = 1'b0;
               mosi_nxt    = 1'b0;
               rx_data_nxt = rx_shift;
               done_nxt    = sel_oh;
               gap_cnt_nxt = '0;
            end
         end
         GAP:     gap_cnt_nxt = gap_cnt + GW'(1);
         default: ;
      endcase
   end

   assign bus.sclk    = sclk_r;
   assign bus.cs_n    = cs_n_r;
   assign bus.sending = sending_r;
   assign bus.mosi    = mosi_r;
   assign bus.gnt     = gnt_r;
   assign bus.done    = done_r;
   assign bus.rx_data = rx_data_r;
   assign bus.busy    = busy_r;
endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: two instances (CLK_DIV=2/CS_GAP=2 and CLK_DIV=1/CS_GAP=0)
// share one mode-0 slave model that follows whichever instance use_b selects.
module tb_spi_master_sched;
   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic use_b  = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_master_sched_if #(.NREQ(2)) a_if ();
   spi_master_sched_if #(.NREQ(2)) b_if ();

   spi_master_sched #(.NREQ(2), .CLK_DIV(2), .CS_GAP(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
   spi_master_sched #(.NREQ(2), .CLK_DIV(1), .CS_GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

   logic [1:0] m_gnt, m_done, m_cs_n;
   logic [7:0] m_rx;
   logic       m_sclk, m_sending, m_mosi, m_busy;
   assign m_gnt     = use_b ? b_if.gnt     : a_if.gnt;
   assign m_done    = use_b ? b_if.done    : a_if.done;
   assign m_cs_n    = use_b ? b_if.cs_n    : a_if.cs_n;
   assign m_rx      = use_b ? b_if.rx_data : a_if.rx_data;
   assign m_sclk    = use_b ? b_if.sclk    : a_if.sclk;
   assign m_sending = use_b ? b_if.sending : a_if.sending;
   assign m_mosi    = use_b ? b_if.mosi    : a_if.mosi;
   assign m_busy    = use_b ? b_if.busy    : a_if.busy;

   logic [7:0] slv_tx    = 8'h00;
   logic [7:0] slv_sh    = 8'h00;
   logic [7:0] mosi_byte = 8'h00;
   logic       miso_v    = 1'b0;
   logic       p_sclk    = 1'b0;
   logic       p_sending = 1'b0;
   logic       both_low  = 1'b0;
   int         rises     = 0;
   int         gnt1_cnt  = 0;
   int         cs_low [2] = '{0, 0};
   logic [7:0] rr_slv [4] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};

   assign a_if.miso = miso_v;
   assign b_if.miso = miso_v;

   // Slave presents MSB when selected and advances on each sclk fall; master bits logged at rises.
   always @(negedge clk) begin
      if (m_sending && !p_sending) begin
         slv_sh = slv_tx;
         miso_v = slv_sh[7];
      end else if (m_sending && p_sclk && !m_sclk) begin
         slv_sh = {slv_sh[6:0], 1'b0};
         miso_v = slv_sh[7];
      end
      if (m_sclk && !p_sclk) begin
         rises++;
         mosi_byte = {mosi_byte[6:0], m_mosi};
      end
      for (int i = 0; i < 2; i++) if (!m_cs_n[i]) cs_low[i]++;
      if (m_cs_n == 2'b00) both_low = 1'b1;
      if (m_gnt[1]) gnt1_cnt++;
      p_sclk    = m_sclk;
      p_sending = m_sending;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      rises     = 0;
      mosi_byte = 8'h00;
      cs_low[0] = 0;
      cs_low[1] = 0;
      gnt1_cnt  = 0;
   endtask

   task automatic set_req(input logic [1:0] r, input logic [15:0] d);
      if (use_b) begin
         b_if.req = r;
         b_if.req_data = d;
      end else begin
         a_if.req = r;
         a_if.req_data = d;
      end
   endtask

   task automatic wait_gnt(output int t, output logic [1:0] g);
      g = 2'b00;
      t = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (m_gnt != 2'b00) begin
            g = m_gnt;
            t = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done(output int t, output logic [1:0] d, output logic [7:0] rx);
      d  = 2'b00;
      t  = -1;
      rx = 8'h00;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (m_done != 2'b00) begin
            d  = m_done;
            t  = cyc;
            rx = m_rx;
            break;
         end
      end
   endtask

   // One complete transfer: request held until granted, then dropped.
   task automatic xfer(input logic [1:0] r, input logic [15:0] d, input logic [7:0] s,
                       output int tg, output int td, output logic [1:0] g,
                       output logic [1:0] dn, output logic [7:0] rx);
      clr_mon();
      slv_tx = s;
      set_req(r, d);
      wait_gnt(tg, g);
      set_req(2'b00, d);
      wait_done(td, dn, rx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         tg, td, tg0, n_done;
      logic [1:0] g, d;
      logic [7:0] rx;

      a_if.req = '0;
      a_if.req_data = '0;
      b_if.req = '0;
      b_if.req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_sclk", a_if.sclk, 1'b0);
      chk("rst_cs_n", a_if.cs_n, 2'b11);
      chk("rst_sending", a_if.sending, 1'b0);
      chk("rst_mosi", a_if.mosi, 1'b0);
      chk("rst_gnt", a_if.gnt, 2'b00);
      chk("rst_done", a_if.done, 2'b00);
      chk("rst_rx_data", a_if.rx_data, 8'h00);
      chk("rst_busy", a_if.busy, 1'b0);
      rst = 1'b0;

      // Single transfer, CLK_DIV=2
      xfer(2'b01, 16'h00A5, 8'h3C, tg, td, g, d, rx);
      chk("s1_gnt", g, 2'b01);
      chk("s1_done", d, 2'b01);
      chk("s1_latency", td - tg, 34);
      chk("s1_rx", rx, 8'h3C);
      chk("s1_mosi", mosi_byte, 8'hA5);
      chk("s1_rises", rises, 8);
      chk("s1_cs0_low", cs_low[0], 34);
      chk("s1_cs1_low", cs_low[1], 0);
      @(negedge clk);
      chk("s1_done_pulse", m_done, 2'b00);
      chk("s1_busy_gap", m_busy, 1'b1);

      // Round robin with both requesters held, starting from reset pointer
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr_mon();
      slv_tx = rr_slv[0];
      set_req(2'b11, 16'h2211);
      tg0 = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(tg, g);
         chk($sformatf("rr_gnt%0d", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) chk($sformatf("rr_spacing%0d", k), tg - tg0, 37);
         tg0 = tg;
         wait_done(td, d, rx);
         chk($sformatf("rr_done%0d", k), d, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr_rx%0d", k), rx, rr_slv[k]);
         chk($sformatf("rr_mosi%0d", k), mosi_byte, (k % 2 == 0) ? 8'h11 : 8'h22);
         if (k == 3) set_req(2'b00, 16'h0000);
         if (k < 3) slv_tx = rr_slv[k+1];
         clr_mon();
      end

      // Boundary bytes
      xfer(2'b01, 16'h0000, 8'hFF, tg, td, g, d, rx);
      chk("b0_rx", rx, 8'hFF);
      chk("b0_rises", rises, 8);
      chk("b0_mosi", mosi_byte, 8'h00);
      xfer(2'b10, 16'hFF00, 8'h00, tg, td, g, d, rx);
      chk("b1_gnt", g, 2'b10);
      chk("b1_rx", rx, 8'h00);
      chk("b1_rises", rises, 8);
      chk("b1_mosi", mosi_byte, 8'hFF);

      // Reset mid-transfer, then pointer restarts at requester 0
      clr_mon();
      slv_tx = 8'hAA;
      set_req(2'b01, 16'h0096);
      wait_gnt(tg, g);
      set_req(2'b00, 16'h0000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_cs_n", a_if.cs_n, 2'b11);
      chk("mrst_sclk", a_if.sclk, 1'b0);
      chk("mrst_sending", a_if.sending, 1'b0);
      chk("mrst_busy", a_if.busy, 1'b0);
      rst = 1'b0;
      n_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (a_if.done != 2'b00) n_done++;
      end
      chk("mrst_no_done", n_done, 0);
      chk("mrst_rx_data", a_if.rx_data, 8'h00);
      set_req(2'b11, 16'h4433);
      wait_gnt(tg, g);
      chk("mrst_first_gnt", g, 2'b01);
      set_req(2'b10, 16'h4433);
      wait_done(td, d, rx);
      wait_gnt(tg, g);
      chk("mrst_second_gnt", g, 2'b10);
      set_req(2'b00, 16'h0000);
      wait_done(td, d, rx);
      chk("mrst_second_done", d, 2'b10);

      // Short req[1] pulse during a busy transfer is dropped
      clr_mon();
      slv_tx = 8'h00;
      set_req(2'b01, 16'h00C3);
      wait_gnt(tg, g);
      set_req(2'b00, 16'h0000);
      repeat (5) @(negedge clk);
      set_req(2'b10, 16'h7700);
      @(negedge clk);
      set_req(2'b00, 16'h0000);
      wait_done(td, d, rx);
      repeat (40) @(negedge clk);
      chk("pulse_no_gnt1", gnt1_cnt, 0);
      chk("pulse_no_cs1", cs_low[1], 0);

      // req[1] raised in the done[0] cycle
      set_req(2'b01, 16'h0011);
      wait_gnt(tg, g);
      set_req(2'b00, 16'h0011);
      wait_done(td, d, rx);
      set_req(2'b10, 16'h5A00);
      wait_gnt(tg, g);
      chk("late_gnt", g, 2'b10);
      chk("late_spacing", tg - td, 3);
      set_req(2'b00, 16'h0000);
      wait_done(td, d, rx);

      // CLK_DIV=1, CS_GAP=0 instance, requester 0 held across two transfers
      use_b = 1'b1;
      clr_mon();
      slv_tx = 8'h3C;
      set_req(2'b01, 16'h00A5);
      wait_gnt(tg, g);
      chk("fast_gnt", g, 2'b01);
      wait_done(td, d, rx);
      chk("fast_done", d, 2'b01);
      chk("fast_latency", td - tg, 17);
      chk("fast_rx", rx, 8'h3C);
      chk("fast_mosi", mosi_byte, 8'hA5);
      chk("fast_rises", rises, 8);
      chk("fast_cs0_low", cs_low[0], 17);
      slv_tx = 8'h81;
      clr_mon();
      tg0 = tg;
      wait_gnt(tg, g);
      chk("fast_next_gnt", tg - tg0, 18);
      set_req(2'b00, 16'h0000);
      wait_done(td, d, rx);
      chk("fast_rx2", rx, 8'h81);
      chk("fast_mosi2", mosi_byte, 8'hA5);

      chk("cs_exclusive", both_low, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
